// File: rtl/physical_tx_gearbox.sv
// 8-bit to 2-bit DDR transmit gearbox feeding a data-lane ODDR (D1 = rising bit, D2 = falling bit).
// Sends TRAIN_WORD bursts after reset or on request, otherwise user data or IDLE_WORD filler.
`timescale 1ns/1ps

module physical_tx_gearbox #(
    parameter logic [7:0]  TRAIN_WORD = 8'hA5,
    parameter logic [7:0]  IDLE_WORD  = 8'hBC,
    parameter int unsigned TRAIN_LEN  = 64
) (
    input  logic       i_clk_600,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic       i_train,
    output logic       o_train_active,
    output logic       o_d1,
    output logic       o_d2
);

    localparam logic ST_TRAIN = 1'b0;
    localparam logic ST_DATA  = 1'b1;

    localparam logic [7:0] LAST_CNT = 8'(TRAIN_LEN - 1);

    logic       r_state;
    logic [1:0] r_phase;
    logic [7:0] r_cnt;
    logic       r_pend;
    logic [7:0] r_word;
    logic       r_d1;
    logic       r_d2;
    logic       r_train_active;

    logic       w_phase3;
    logic       w_start_train;
    logic       w_accept;

    assign w_phase3 = (r_phase == 2'd3);

    // NOTE: o_ready is combinational and gated by reset so a DATA phase-3 state left over
    // from before reset cannot signal an accept while reset is held.
    assign o_ready = !i_rst && (r_state == ST_DATA) && w_phase3 && !r_pend && !i_train;

    assign w_start_train = (r_state == ST_DATA) && w_phase3 && (r_pend || i_train);
    assign w_accept      = i_valid && o_ready;

    always_ff @(posedge i_clk_600) begin
        if (i_rst) begin
            r_state        <= ST_TRAIN;
            r_phase        <= 2'd0;
            r_cnt          <= 8'd0;
            r_pend         <= 1'b0;
            r_word         <= TRAIN_WORD;
            r_d1           <= 1'b0;
            r_d2           <= 1'b0;
            r_train_active <= 1'b1;
        end else begin
            r_phase <= r_phase + 2'd1;
            r_d1    <= r_word[{r_phase, 1'b0}];
            r_d2    <= r_word[{r_phase, 1'b1}];

            if (r_state == ST_TRAIN) begin
                // The word loaded at reset or burst start is training word #1, so the
                // burst ends on the load that follows word TRAIN_LEN.
                if (w_phase3) begin
                    r_cnt <= r_cnt + 8'd1;
                    if (r_cnt == LAST_CNT) begin
                        r_state        <= ST_DATA;
                        r_train_active <= 1'b0;
                        r_word         <= IDLE_WORD;
                    end else begin
                        r_word <= TRAIN_WORD;
                    end
                end
            end else begin
                if (w_start_train) begin
                    r_state        <= ST_TRAIN;
                    r_train_active <= 1'b1;
                    r_cnt          <= 8'd0;
                    r_pend         <= 1'b0;
                    r_word         <= TRAIN_WORD;
                end else begin
                    if (i_train) begin
                        r_pend <= 1'b1;
                    end
                    if (w_phase3) begin
                        r_word <= w_accept ? i_data : IDLE_WORD;
                    end
                end
            end
        end
    end

    assign o_d1           = r_d1;
    assign o_d2           = r_d2;
    assign o_train_active = r_train_active;

endmodule

// File: tb/tb_physical_tx_gearbox.sv
// Self-checking bench for physical_tx_gearbox with TRAIN_LEN=4: per-cycle expected
// {d1,d2,train_active,ready} entries are queued with the stimulus and popped as outputs appear.
`timescale 1ns/1ps

module tb_physical_tx_gearbox;

    typedef struct {
        logic d1;
        logic d2;
        logic ta;
        logic rdy;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic [7:0] pairs;
    } vec_t;

    // Output pairs of a word in serial order, {d1,d2} of phase 0 in bits [7:6].
    localparam logic [7:0] P_A5 = 8'b10_10_01_01;
    localparam logic [7:0] P_BC = 8'b00_11_11_01;
    localparam logic [7:0] P_3C = 8'b00_11_11_00;
    localparam logic [7:0] P_F0 = 8'b00_00_11_11;

    logic       clk;
    logic       i_rst;
    logic [7:0] i_data;
    logic       i_valid;
    logic       o_ready;
    logic       i_train;
    logic       o_train_active;
    logic       o_d1;
    logic       o_d2;

    exp_t exp_q[$];
    vec_t tbl[3];
    int   total;
    int   bad;
    int   acc_cnt;
    int   a0;

    physical_tx_gearbox #(
        .TRAIN_WORD (8'hA5),
        .IDLE_WORD  (8'hBC),
        .TRAIN_LEN  (4)
    ) dut (
        .i_clk_600      (clk),
        .i_rst          (i_rst),
        .i_data         (i_data),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_train        (i_train),
        .o_train_active (o_train_active),
        .o_d1           (o_d1),
        .o_d2           (o_d2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic push_pair(input logic d1, input logic d2, input logic ta, input logic rdy);
        exp_t e;
        e.d1  = d1;
        e.d2  = d2;
        e.ta  = ta;
        e.rdy = rdy;
        exp_q.push_back(e);
    endtask

    // The last pair of a word is driven on the phase-3 edge, which also sets the state of the next word.
    task automatic push_word(input logic [7:0] pairs, input logic ta_this, input logic ta_next,
                             input logic rdy_last);
        push_pair(pairs[7], pairs[6], ta_this, 1'b0);
        push_pair(pairs[5], pairs[4], ta_this, 1'b0);
        push_pair(pairs[3], pairs[2], ta_this, 1'b0);
        push_pair(pairs[1], pairs[0], ta_next, rdy_last);
    endtask

    task automatic push_burst();
        push_word(P_A5, 1'b1, 1'b1, 1'b0);
        push_word(P_A5, 1'b1, 1'b1, 1'b0);
        push_word(P_A5, 1'b1, 1'b1, 1'b0);
        push_word(P_A5, 1'b1, 1'b0, 1'b0);
        push_word(P_BC, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic run(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL queue_underflow: got 0 entries expected >0 at %0t", $time);
                @(posedge clk);
                #1;
            end else begin
                e = exp_q[0];
                check("o_ready", {31'd0, o_ready}, {31'd0, e.rdy});
                if (i_valid && o_ready) acc_cnt++;
                @(posedge clk);
                #1;
                e = exp_q.pop_front();
                check("d1d2", {30'd0, o_d1, o_d2}, {30'd0, e.d1, e.d2});
                check("train_active", {31'd0, o_train_active}, {31'd0, e.ta});
            end
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        acc_cnt = 0;
        i_rst   = 1'b1;
        i_data  = 8'h00;
        i_valid = 1'b0;
        i_train = 1'b0;

        tbl[0] = '{data: 8'h01, pairs: 8'b10_00_00_00};
        tbl[1] = '{data: 8'h80, pairs: 8'b00_00_00_01};
        tbl[2] = '{data: 8'hFF, pairs: 8'b11_11_11_11};

        // Reset state
        push_pair(1'b0, 1'b0, 1'b1, 1'b0);
        push_pair(1'b0, 1'b0, 1'b1, 1'b0);
        run(2);
        check("ready_in_reset", {31'd0, o_ready}, 32'd0);

        // Release: four training words, then idle filler
        i_rst = 1'b0;
        push_burst();
        run(20);

        // Back-to-back words from the table
        a0 = acc_cnt;
        for (int i = 0; i < 3; i++) begin
            i_data  = tbl[i].data;
            i_valid = 1'b1;
            if (i == 0) push_word(P_BC, 1'b0, 1'b0, 1'b1);
            else        push_word(tbl[i-1].pairs, 1'b0, 1'b0, 1'b1);
            run(4);
        end
        check("b2b_accepts", acc_cnt - a0, 32'd3);

        // Held valid while not ready: sent exactly once
        i_data  = 8'h3C;
        push_word(tbl[2].pairs, 1'b0, 1'b0, 1'b1);
        run(4);
        i_valid = 1'b0;
        push_word(P_3C, 1'b0, 1'b0, 1'b1);
        run(4);
        check("held_valid_accepts", acc_cnt - a0, 32'd4);

        // Training request mid-word: F0 completes, burst follows; i_train in TRAIN is ignored
        i_data  = 8'hF0;
        i_valid = 1'b1;
        push_word(P_BC, 1'b0, 1'b0, 1'b1);
        run(4);
        i_valid = 1'b0;
        a0 = acc_cnt;
        push_word(P_F0, 1'b0, 1'b1, 1'b0);
        run(1);
        i_train = 1'b1;
        run(1);
        i_train = 1'b0;
        run(2);
        push_burst();
        run(6);
        i_train = 1'b1;
        run(1);
        i_train = 1'b0;
        run(13);
        check("train_req_accepts", acc_cnt - a0, 32'd0);

        // i_train and i_valid together at phase 3: training wins, word waits
        a0 = acc_cnt;
        i_data  = 8'h3C;
        i_valid = 1'b1;
        push_word(P_BC, 1'b0, 1'b1, 1'b0);
        run(3);
        i_train = 1'b1;
        run(1);
        i_train = 1'b0;
        check("train_wins_no_accept", acc_cnt - a0, 32'd0);
        push_burst();
        run(20);
        check("deferred_accept", acc_cnt - a0, 32'd1);
        i_valid = 1'b0;
        push_word(P_3C, 1'b0, 1'b0, 1'b1);
        run(4);

        // Reset during a data word
        push_pair(1'b0, 1'b0, 1'b0, 1'b0);
        push_pair(1'b1, 1'b1, 1'b0, 1'b0);
        run(2);
        i_rst = 1'b1;
        push_pair(1'b0, 1'b0, 1'b1, 1'b0);
        run(1);
        i_rst = 1'b0;
        push_burst();
        run(20);

        // Reset during the second training word
        i_rst = 1'b1;
        push_pair(1'b0, 1'b0, 1'b1, 1'b0);
        run(1);
        i_rst = 1'b0;
        push_word(P_A5, 1'b1, 1'b1, 1'b0);
        push_pair(1'b1, 1'b0, 1'b1, 1'b0);
        push_pair(1'b1, 1'b0, 1'b1, 1'b0);
        run(6);
        i_rst = 1'b1;
        push_pair(1'b0, 1'b0, 1'b1, 1'b0);
        run(1);
        i_rst = 1'b0;
        push_burst();
        run(20);

        check("queue_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/physical_tx_gearbox.md
PHYSICAL_TX_GEARBOX -- requirements
Module: physical_tx_gearbox

Interface
REQ-001 SHALL have parameter TRAIN_WORD, default 8'hA5; training word, serialized LSB first.
REQ-002 SHALL have parameter IDLE_WORD, default 8'hBC; filler word sent in DATA state when no input word is valid.
REQ-003 SHALL have parameter TRAIN_LEN, default 64; number of training words per training burst; legal range 1..255.
REQ-004 i_clk_600  input  1  sole clock; the same 600 MHz clock that drives the forwarded-clock ODDR.
REQ-005 i_rst  input  1  synchronous, active-high reset.
REQ-006 i_data  input  8  parallel transmit word.
REQ-007 i_valid  input  1  i_data is valid.
REQ-008 o_ready  output  1  word accepted on this edge when i_valid=1.
REQ-009 i_train  input  1  level request to start a new training burst.
REQ-010 o_train_active  output  1  high while in TRAIN state.
REQ-011 o_d1  output  1  rising-edge bit to data-lane ODDR D1.
REQ-012 o_d2  output  1  falling-edge bit to data-lane ODDR D2.

Function
REQ-013 SHALL serialize one 8-bit word over 4 clocks: phase p (0..3) drives o_d1=word[2p] and o_d2=word[2p+1].
REQ-014 SHALL register o_d1 and o_d2; on the edge where phase=p, they load bits 2p and 2p+1 of the current-word register.
REQ-015 SHALL keep a 2-bit phase counter that increments every edge and wraps 3->0.
REQ-016 SHALL load the current-word register only on edges where phase=3.
REQ-017 SHALL implement two states: TRAIN and DATA.
REQ-018 TRAIN: each phase-3 load SHALL be TRAIN_WORD, and a word counter SHALL increment on each load.
REQ-019 TRAIN: on the phase-3 edge that completes the TRAIN_LEN-th training word, the FSM SHALL move to DATA and load the first DATA-state word.
REQ-020 DATA: a phase-3 load SHALL take i_data when i_valid=1 and IDLE_WORD otherwise.
REQ-021 o_ready SHALL be combinational and equal (state=DATA && phase=3 && !train_pend && !i_train).
REQ-022 A transfer SHALL occur only when i_valid && o_ready; i_data SHALL be sampled on that edge.
REQ-023 Latency: i_data bits[1:0] SHALL appear on o_d1/o_d2 after the edge following the accept edge; bits[7:6] SHALL appear 3 edges later.
REQ-024 i_train=1 in DATA SHALL set train_pend.
REQ-025 At the next phase-3 edge with train_pend set: TRAIN_WORD SHALL load, the counter SHALL clear to 0, the FSM SHALL enter TRAIN, and train_pend SHALL clear.
REQ-026 A word already being serialized when i_train rises SHALL complete unaltered.
REQ-027 If i_train and i_valid are both high at a DATA phase-3 edge, training SHALL win: o_ready=0, no accept, TRAIN_WORD loads.
REQ-028 i_train during TRAIN SHALL be ignored; the burst is not extended or restarted.
REQ-029 o_train_active SHALL be registered, high exactly while the FSM is in TRAIN.
REQ-030 The word counter SHALL be at least 8 bits wide and SHALL never exceed TRAIN_LEN.

Reset
REQ-031 While i_rst=1 on an edge, the block SHALL set: state=TRAIN, phase=0, counter=0, train_pend=0, current word=TRAIN_WORD, o_d1=0, o_d2=0, o_train_active=1; o_ready SHALL be 0.
REQ-032 On the first edge after i_rst falls, o_d1/o_d2 SHALL output TRAIN_WORD bits[1:0], and a full TRAIN_LEN burst SHALL follow.
REQ-033 Reset asserted mid-word or mid-burst SHALL abort immediately with no partial completion; after release, the block behaves as from a fresh reset.

Verification
REQ-034 Reset release, TRAIN_LEN=4, i_valid=0: 16 cycles of TRAIN_WORD pattern (o_d1,o_d2 = 1,0 / 1,0 / 0,1 / 0,1 for 8'hA5), then o_train_active=0, then IDLE_WORD pattern.
REQ-035 Back-to-back i_valid with words 8'h01, 8'h80, 8'hFF: each is accepted exactly on a phase-3 edge, 4 cycles apart; output pairs follow REQ-013 with no gaps and no IDLE_WORD inserted.
REQ-036 i_valid held with 8'h3C while o_ready=0 for 3 cycles: no accept until the phase-3 edge; 8'h3C is sent exactly once.
REQ-037 i_train pulsed at DATA phase 1 while 8'hF0 is serializing: 8'hF0 completes, then TRAIN_LEN TRAIN_WORDs, o_ready=0 throughout, then DATA resumes.
REQ-038 i_train and i_valid both high at phase 3: o_ready=0, the word is not consumed, the training burst starts, and the same word is accepted at the first DATA phase-3 edge.
REQ-039 i_rst asserted during the 2nd word of training and during a data word: outputs read 0 on the next edge and restart per REQ-032.
